// File: rtl/pipe_pkg.sv
// Shared pipeline types: per-stage payload structs, their bubble values and
// packed widths, plus a small helper used by the stage buffer.
package pipe_pkg;

  localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

  typedef enum logic [3:0] {
    ALU_ADDU, ALU_SUBU, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef enum logic [1:0] {
    MEM_SIZE_1 = 2'd0,
    MEM_SIZE_2 = 2'd1,
    MEM_SIZE_4 = 2'd2
  } mem_size_e;

  typedef logic [1:0] occ_t;

  // fetch -> decode
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  // decode -> execute
  typedef struct packed {
    logic [31:0] pc;
    alu_op_e     alu_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    mem_size_e   mem_size;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic        reg_wr_en;
  } id_ex_t;

  // execute -> memory
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    mem_size_e   mem_size;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic        reg_wr_en;
  } ex_mem_t;

  // memory -> writeback
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        reg_wr_en;
  } mem_wb_t;

  localparam int unsigned IF_ID_W  = $bits(if_id_t);
  localparam int unsigned ID_EX_W  = $bits(id_ex_t);
  localparam int unsigned EX_MEM_W = $bits(ex_mem_t);
  localparam int unsigned MEM_WB_W = $bits(mem_wb_t);

  // Bubbles are harmless no-ops: reset PC, addu, word size, every enable off.
  localparam if_id_t IF_ID_BUBBLE = '{pc: RESET_PC, instr: 32'h0000_0000};

  localparam id_ex_t ID_EX_BUBBLE = '{
    pc: RESET_PC, alu_op: ALU_ADDU, rs_val: 32'h0, rt_val: 32'h0, imm: 32'h0,
    rd: 5'd0, mem_size: MEM_SIZE_4, mem_rd_en: 1'b0, mem_wr_en: 1'b0,
    reg_wr_en: 1'b0
  };

  localparam ex_mem_t EX_MEM_BUBBLE = '{
    pc: RESET_PC, alu_result: 32'h0, store_data: 32'h0, rd: 5'd0,
    mem_size: MEM_SIZE_4, mem_rd_en: 1'b0, mem_wr_en: 1'b0, reg_wr_en: 1'b0
  };

  localparam mem_wb_t MEM_WB_BUBBLE = '{
    pc: RESET_PC, wb_data: 32'h0, rd: 5'd0, reg_wr_en: 1'b0
  };

  function automatic occ_t occ_count(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake, flush and an
// optional two-entry skid mode that breaks the ready path between stages.
// Main is the head entry and always holds BUBBLE when empty, so out_data
// needs no output mux.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter bit               SKID   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_ready_q, in_ready_d;
  logic             in_xfer, out_xfer;

  // In skid mode in_ready comes only from a flop; masking with reset keeps
  // it low during reset yet high on the very first cycle after release.
  assign in_ready  = (SKID ? in_ready_q : (~main_valid_q | out_ready)) & ~reset;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign occupancy = occ_count(main_valid_q, skid_valid_q);

  // Next-state for the main/skid entries; flush beats every transfer.
  always_comb begin
    in_xfer      = in_valid & in_ready;
    out_xfer     = main_valid_q & out_ready;
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      main_data_d  = BUBBLE;
      skid_valid_d = 1'b0;
      skid_data_d  = BUBBLE;
    end else if (SKID) begin
      if (!main_valid_q) begin
        if (in_xfer) begin
          main_valid_d = 1'b1;
          main_data_d  = in_data;
        end
      end else if (!skid_valid_q) begin
        if (in_xfer && out_xfer) begin
          main_data_d = in_data;
        end else if (in_xfer) begin
          skid_valid_d = 1'b1;
          skid_data_d  = in_data;
        end else if (out_xfer) begin
          main_valid_d = 1'b0;
          main_data_d  = BUBBLE;
        end
      end else if (out_xfer) begin
        // full: in_ready is low, so only the drain case applies
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
        skid_data_d  = BUBBLE;
      end
    end else begin
      if (in_xfer) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else if (out_xfer) begin
        main_valid_d = 1'b0;
        main_data_d  = BUBBLE;
      end
    end
    in_ready_d = ~skid_valid_d;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= BUBBLE;
      skid_valid_q <= 1'b0;
      skid_data_q  <= BUBBLE;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // Structural invariants: skid never holds data without a head, and an
  // empty stage always presents the bubble.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!skid_valid_q || main_valid_q);
      assert (main_valid_q || (main_data_q == BUBBLE));
    end
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Generic inter-stage pipeline register for the five-stage core. Replaces the hand-written per-stage latches (F/D/E/M/W).
- Carries an arbitrary packed payload using a valid/ready handshake.
- Supports flush (squash to bubble) and back-pressure (the stall source is downstream not-ready).
- Optional 2-entry skid mode registers the ready path, so long stall chains no longer form one combinational ready path across stages.

Parameters:
- WIDTH, 32: payload width in bits (a packed stage struct is cast to this).
- BUBBLE, '0: payload value presented when empty, after reset and after flush.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  squash all held entries this cycle
- in_valid  in  1  upstream stage offers a payload
- in_ready  out  1  this stage can accept a payload
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  held payload is valid
- out_ready  in  1  downstream accepts the payload (low = stall)
- out_data  out  WIDTH  held payload, or BUBBLE when not valid
- occupancy  out  2  number of entries held (0..2; never exceeds 1 when SKID=0)

Behaviour:
- Transfers:
  - An input transfer (in_xfer) occurs when in_valid && in_ready at a clk edge.
  - An output transfer (out_xfer) occurs when out_valid && out_ready at a clk edge.
- Reset (sampled at clk):
  - main_valid = 0, skid_valid = 0.
  - out_data = BUBBLE, occupancy = 0.
  - in_ready = 0 while reset is high; in_ready = 1 on the first cycle after reset is released.
- Flush (sampled at clk, no reset):
  - Both entries are invalidated and out_data becomes BUBBLE.
  - An in_xfer in the same cycle is accepted (in_ready is not gated by flush) and discarded.
  - Flush has priority over every transfer. Reset has priority over flush.
- SKID=0 mode:
  - in_ready = ~main_valid | out_ready (combinational).
  - On in_xfer, main is loaded with in_data and main_valid is set to 1.
  - On out_xfer without in_xfer, main_valid is cleared to 0 and out_data becomes BUBBLE.
  - Latency is 1 cycle. Throughput is 1 payload per cycle under continuous ready.
- SKID=1 mode:
  - in_ready = ~skid_valid, taken from a flop; no path from out_ready.
  - Main holds the head entry; skid holds the overflow entry.
  - Cases, evaluated in this order:
    - Empty + in_xfer: load main.
    - Main only, in_xfer and out_xfer: load main with in_data.
    - Main only, in_xfer without out_xfer: load skid.
    - Main only, out_xfer without in_xfer: empty.
    - Full (in_ready = 0), out_xfer: skid moves to main, skid is cleared.
  - Entries leave in FIFO order; no payload is duplicated or dropped except on flush.
  - Latency is 1 cycle when empty. Sustained throughput is 1 per cycle.
- Outputs:
  - out_data is driven from the main register. Whenever main_valid = 0, main holds BUBBLE, so no combinational mux on the output is needed.
  - occupancy = main_valid + skid_valid.
- Assertions (simulation only):
  - skid_valid implies main_valid.
  - out_data == BUBBLE whenever !out_valid.

Decomposition:
- Shared package `pipe_pkg`:
  - per-stage payload structs (decode→execute, execute→memory, …);
  - their bubble constants (e.g. the execute bubble has PC = 32'hbfc00000, ALU op = addu, mem size = 4 bytes, all enables 0);
  - a `stage_width` localparam for each struct.
- No sub-module is needed. The skid entry is two registers plus the case logic above, which sits naturally inline.
- Instantiate one pipe_stage_buf per stage boundary.

Test Plan:
- Reset, then in_valid=1 with in_data=32'h1234_5678 and out_ready=1 → next cycle out_valid=1 and out_data=32'h1234_5678. Streaming values 1,2,3 on consecutive cycles emerge 1,2,3 with no gaps.
- SKID=1, main holds A=32'hA, out_ready=0, offer B=32'hB → occupancy=2 and in_ready=0 the next cycle. Raise out_ready → A, then B on consecutive cycles; in_ready=1 the cycle after A leaves.
- SKID=0, main holds A, out_ready=0 → in_ready=0 in the same cycle (combinational). Raise out_ready together with in_valid carrying C → next cycle out_data=C.
- Occupancy 2, flush=1 together with in_valid carrying D → next cycle out_valid=0, out_data=BUBBLE (e.g. 32'hbfc00000 pattern), occupancy=0, and D never appears.
- Occupancy 2, assert reset for one cycle mid-stream → out_valid=0, occupancy=0, in_ready=0 during reset; in_ready=1 after release; the old entries never appear.
- Random in_valid/out_ready (10k cycles, both SKID values) → output sequence equals the input sequence, and the assertions hold.
